// File: rtl/ps2_keycode_if.sv
// ps2_keycode_if: PS/2 keyboard lines plus the decoded key outputs.
//   ps2_clk, ps2_data : raw asynchronous PS/2 lines (keyboard -> decoder)
//   keycode           : USB-HID usage of the held key, 0x00 when none
//   key_event         : one-cycle pulse when keycode changes
//   frame_err         : one-cycle pulse on framing/parity error or timeout
interface ps2_keycode_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;
    modport master (output ps2_clk, ps2_data, input keycode, key_event, frame_err);
    modport slave  (input ps2_clk, ps2_data, output keycode, key_event, frame_err);
endinterface

// File: rtl/ps2_keycode.sv
// ps2_keycode: PS/2 receiver and scan-code decoder producing a held-key HID usage.
//   Clk     : system clock, rising edge
//   Reset_n : synchronous active-low reset
//   bus     : ps2_keycode_if.slave (ps2_clk/ps2_data in; keycode/key_event/frame_err out)
module ps2_keycode #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic          Clk,
    input logic          Reset_n,
    ps2_keycode_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nxt;
    logic            c_meta, c_sync, c_prev, d_meta, d_sync;
    logic            fall, tmo;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bit;
    logic [TW-1:0]   tmo_cnt;
    logic            brk, ext;
    logic            byte_done, frame_ok, accept, err, mapped;
    logic [7:0]      usage, key_nxt;

    // Synchronizers idle high so reset looks like a quiet bus.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            {c_meta, c_sync, c_prev, d_meta, d_sync} <= '1;
        end else begin
            c_meta <= bus.ps2_clk;
            c_sync <= c_meta;
            c_prev <= c_sync;
            d_meta <= bus.ps2_data;
            d_sync <= d_meta;
        end
    end

    assign fall = c_prev & ~c_sync;
    // A falling edge in the same cycle rescues the frame from the timeout.
    assign tmo  = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tmo) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    state_nxt = d_sync ? IDLE : DATA;
                DATA:    state_nxt = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (state == IDLE || fall || tmo) ? '0 : tmo_cnt + 1'b1;
            if (state == IDLE)
                bit_cnt <= '0;
            else if (fall && state == DATA)
                bit_cnt <= bit_cnt + 1'b1;
            if (fall && state == DATA)
                shift <= {d_sync, shift[7:1]};
            if (fall && state == PARITY)
                par_bit <= d_sync;
        end
    end

    always_comb begin
        byte_done = fall && (state == STOP);
        frame_ok  = d_sync && (^{shift, par_bit});
        accept    = byte_done && frame_ok;
        err       = tmo || (byte_done && !frame_ok);
        usage     = (shift == 8'h1C) ? 8'h04 :
                    (shift == 8'h23) ? 8'h07 :
                    (shift == 8'h1D) ? 8'h1A :
                    (shift == 8'h1B) ? 8'h16 :
                    (shift == 8'h29) ? 8'h2C : 8'h00;
        mapped    = accept && !ext && (usage != 8'h00);
        // A break only clears the key it names; an older key's release is ignored.
        key_nxt   = !mapped ? bus.keycode :
                    !brk    ? usage :
                    (usage == bus.keycode) ? 8'h00 : bus.keycode;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.keycode   <= 8'h00;
            bus.key_event <= 1'b0;
            bus.frame_err <= 1'b0;
            brk           <= 1'b0;
            ext           <= 1'b0;
        end else begin
            bus.keycode   <= key_nxt;
            bus.key_event <= key_nxt != bus.keycode;
            bus.frame_err <= err;
            if (accept) begin
                brk <= (shift == 8'hF0) ? 1'b1 : (shift == 8'hE0) ? brk : 1'b0;
                ext <= (shift == 8'hE0) ? 1'b1 : (shift == 8'hF0) ? ext : 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keycode.sv
// tb_ps2_keycode: scoreboard bench driving PS/2 frames against a key-state model.
module tb_ps2_keycode;
    localparam int TMO = 200;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ps2_keycode_if bus ();

    ps2_keycode #(.TIMEOUT_CYCLES(TMO)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] kc;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] held = 8'h00;
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;

    function automatic logic [7:0] usage_of(input logic [7:0] b);
        case (b)
            8'h1C: return 8'h04;
            8'h23: return 8'h07;
            8'h1D: return 8'h1A;
            8'h1B: return 8'h16;
            8'h29: return 8'h2C;
            default: return 8'h00;
        endcase
    endfunction

    // Key-state model: applied to each complete frame at its stop edge.
    task automatic model_frame(input logic [7:0] b, input bit ok, input int at);
        logic [7:0] u, nk;
        exp_t e;
        if (!ok) begin
            e.is_err = 1'b1; e.kc = held; e.at = at;
            sb.push_back(e);
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            u = usage_of(b);
            if (!m_ext && u != 8'h00) begin
                nk = !m_brk ? u : (u == held ? 8'h00 : held);
                if (nk != held) begin
                    e.is_err = 1'b0; e.kc = nk; e.at = at;
                    sb.push_back(e);
                    held = nk;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        bus.ps2_data = v;
        repeat (4) @(negedge Clk);
        bus.ps2_clk = 1'b0;
        repeat (8) @(negedge Clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b, input bit par_ok = 1'b1, input bit stop_ok = 1'b1);
        logic par;
        par = (~^b) ^ !par_ok;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        bus.ps2_data = stop_ok;
        repeat (4) @(negedge Clk);
        bus.ps2_clk = 1'b0;
        model_frame(b, par_ok && stop_ok, cyc + 3);
        repeat (8) @(negedge Clk);
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i]);
        bus.ps2_data = 1'b1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge Clk) begin
        if (bus.key_event === 1'b1 || bus.frame_err === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse ev=%b err=%b kc=%h cyc=%0d",
                         bus.key_event, bus.frame_err, bus.keycode, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.frame_err !== e.is_err || bus.key_event !== !e.is_err ||
                    (!e.is_err && bus.keycode !== e.kc) || (e.at >= 0 && e.at != cyc)) begin
                    bad++;
                    $display("FAIL pulse got ev=%b err=%b kc=%h cyc=%0d want err=%b kc=%h cyc=%0d",
                             bus.key_event, bus.frame_err, bus.keycode, cyc, e.is_err, e.kc, e.at);
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge Clk);
        chk("rst_keycode", bus.keycode, 8'h00);
        chk("rst_event", {7'd0, bus.key_event}, 8'h00);
        chk("rst_err", {7'd0, bus.frame_err}, 8'h00);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);

        send(8'h1C);
        chk("make_A", bus.keycode, 8'h04);
        send(8'h23);
        chk("make_D", bus.keycode, 8'h07);
        send(8'hF0); send(8'h1C);
        chk("break_old_A", bus.keycode, 8'h07);
        send(8'hF0); send(8'h23);
        chk("break_D", bus.keycode, 8'h00);

        send(8'h1C, 1'b0);
        chk("bad_parity_kc", bus.keycode, 8'h00);
        send(8'h1C, 1'b1, 1'b0);
        chk("bad_stop_kc", bus.keycode, 8'h00);

        send_partial(8'h29, 4);
        e.is_err = 1'b1; e.kc = held; e.at = -1;
        sb.push_back(e);
        repeat (TMO + 20) @(negedge Clk);
        chk("timeout_drained", 8'(sb.size()), 8'h00);
        send(8'h29);
        chk("after_timeout", bus.keycode, 8'h2C);

        send(8'hE0); send(8'h1C);
        chk("ext_ignored", bus.keycode, 8'h2C);
        send(8'h5A);
        chk("unmapped", bus.keycode, 8'h2C);
        send(8'h1C); send(8'h1C); send(8'h1C);
        chk("typematic", bus.keycode, 8'h04);

        send_partial(8'h23, 5);
        @(negedge Clk);
        Reset_n = 1'b0;
        held = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
        @(negedge Clk);
        chk("mid_reset_kc", bus.keycode, 8'h00);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        send(8'h1D);
        chk("after_reset", bus.keycode, 8'h1A);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] pool [8];
            logic [7:0] b;
            pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'hF0, 8'hE0, 8'h5A};
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 7)];
            send(b, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0);
        end
        repeat (10) @(negedge Clk);
        chk("final_kc", bus.keycode, held);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
